// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache response block.
package dcache_pkg;

  localparam int DEF_INDEX_W = 6;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS_RD,
    WR_THRU
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Tag/data storage with a registered read port and one write port, plus valid bits
// that can all be cleared in a single cycle.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = 30 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data,
  input  logic               clr_all
);

  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic [LINES-1:0] valid;

  // NOTE: tag/data storage is deliberately left out of reset so it maps onto plain RAM;
  // the valid bits are the only state that must come up known.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_data <= data_mem[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (clr_all)  valid         <= '0;
      else if (we)  valid[wr_idx] <= 1'b1;
      if (rd_en)    rd_valid      <= valid[rd_idx];
    end
  end

endmodule

// File: rtl/dcache_resp.sv
// Direct-mapped, write-through, no-write-allocate data cache: one word per line,
// single outstanding request, memory side held until mem_ack.
module dcache_resp
  import dcache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] p_addr,
  input  logic        p_addr_valid,
  input  logic [1:0]  cache_rw,
  input  logic [31:0] cache_write,
  output logic        cache_ready,
  output logic [31:0] cache_read,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int TAG_W = 30 - INDEX_W;

  state_t      state, state_nx;
  logic [29:0] waddr_q;
  logic        is_wr_q;
  logic [31:0] wdata_q;
  logic        hit_q;
  logic        flush_pend;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               arr_we;
  logic [31:0]        arr_wdata;
  logic               hit;
  logic               req_ok;
  logic               flush_now;
  logic               accept;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^p_addr[1:0];

  assign req_ok    = p_addr_valid && (cache_rw == RW_READ || cache_rw == RW_WRITE);
  // A flush (new or deferred) owns the IDLE cycle, so a request waits one more cycle.
  assign flush_now = (state == IDLE) && (flush || flush_pend);
  assign accept    = (state == IDLE) && !flush_now && req_ok;
  assign hit       = rd_valid && (rd_tag == waddr_q[29:INDEX_W]);

  dcache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (accept),
    .rd_idx   (p_addr[INDEX_W+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (arr_we),
    .wr_idx   (waddr_q[INDEX_W-1:0]),
    .wr_tag   (waddr_q[29:INDEX_W]),
    .wr_data  (arr_wdata),
    .clr_all  (flush_now)
  );

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    cache_ready = 1'b0;
    cache_read  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    arr_we      = 1'b0;
    arr_wdata   = mem_rdata;
    case (state)
      IDLE: if (accept) state_nx = LOOKUP;
      LOOKUP: begin
        if (is_wr_q) begin
          state_nx = WR_THRU;
        end else if (hit) begin
          cache_ready = 1'b1;
          cache_read  = rd_data;
          state_nx    = IDLE;
        end else begin
          state_nx = MISS_RD;
        end
      end
      MISS_RD: begin
        mem_req  = 1'b1;
        mem_addr = {waddr_q, 2'b00};
        if (mem_ack) begin
          arr_we      = 1'b1;
          cache_ready = 1'b1;
          cache_read  = mem_rdata;
          state_nx    = IDLE;
        end
      end
      WR_THRU: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {waddr_q, 2'b00};
        mem_wdata = wdata_q;
        if (mem_ack) begin
          arr_we      = hit_q;
          arr_wdata   = wdata_q;
          cache_ready = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      waddr_q    <= '0;
      is_wr_q    <= 1'b0;
      wdata_q    <= '0;
      hit_q      <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        waddr_q <= p_addr[31:2];
        is_wr_q <= (cache_rw == RW_WRITE);
        wdata_q <= cache_write;
      end
      if (state == LOOKUP) hit_q <= hit;
      if (flush_now)                    flush_pend <= 1'b0;
      else if (flush && state != IDLE)  flush_pend <= 1'b1;
    end
  end

endmodule
